// File: rtl/bl_wl_prog_pkg.sv
// rtl/bl_wl_prog_pkg.sv - shared state type, width helpers and default timing for the BL/WL programmer
package bl_wl_prog_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} prog_state_e;

  localparam int DEF_NUM_ROWS  = 8;
  localparam int DEF_NUM_COLS  = 8;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;

  // Never returns 0 so a degenerate value still yields a legal vector width.
  function automatic int clog2_min1(input int value);
    int w;
    for (w = 0; (1 << w) < value; w++) begin
    end
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bl_wl_phase_timer.sv
// rtl/bl_wl_phase_timer.sv - loadable down-counter shared by the setup, pulse and hold phases
module bl_wl_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_count;

  // Parks at 1 once a phase ends, so the count can never wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count > CNT_W'(1)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_expire = (r_count == CNT_W'(1));

endmodule

// File: rtl/bl_wl_programmer.sv
// rtl/bl_wl_programmer.sv - configuration-memory row writer: drives BL/BLB, then pulses one word line
module bl_wl_programmer
  import bl_wl_prog_pkg::*;
#(
  parameter  int NUM_ROWS  = DEF_NUM_ROWS,
  parameter  int NUM_COLS  = DEF_NUM_COLS,
  parameter  int SETUP_CYC = DEF_SETUP_CYC,
  parameter  int PULSE_CYC = DEF_PULSE_CYC,
  parameter  int HOLD_CYC  = DEF_HOLD_CYC,
  localparam int ROW_W     = clog2_min1(NUM_ROWS)
) (
  input  logic                prog_clk,
  input  logic                prog_rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [ROW_W-1:0]    cfg_row,
  input  logic [NUM_COLS-1:0] cfg_data,
  output logic [NUM_COLS-1:0] bl,
  output logic [NUM_COLS-1:0] blb,
  output logic [NUM_ROWS-1:0] wl,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int             CNT_W     = clog2_min1(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);
  localparam logic [ROW_W:0] ROW_LIMIT = (ROW_W + 1)'(NUM_ROWS);

  prog_state_e         r_state;
  logic [ROW_W-1:0]    r_row;
  logic [NUM_COLS-1:0] r_bl;
  logic [NUM_COLS-1:0] r_blb;
  logic [NUM_ROWS-1:0] r_wl;
  logic                r_done;
  logic                r_err;

  logic                w_take;
  logic                w_row_ok;
  logic                w_load;
  logic [CNT_W-1:0]    w_load_val;
  logic                w_expire;
  logic [NUM_ROWS-1:0] w_wl_sel;

  assign w_take   = cfg_valid && (r_state == IDLE);
  // One extra bit so non-power-of-two row counts can see out-of-range indices.
  assign w_row_ok = ({1'b0, cfg_row} < ROW_LIMIT);

  always_comb begin
    w_load     = 1'b0;
    w_load_val = CNT_W'(SETUP_CYC);
    case (r_state)
      IDLE:  w_load = w_take && w_row_ok;
      SETUP: begin
        w_load     = w_expire;
        w_load_val = CNT_W'(PULSE_CYC);
      end
      PULSE: begin
        w_load     = w_expire;
        w_load_val = CNT_W'(HOLD_CYC);
      end
      default: w_load = 1'b0;
    endcase
  end

  always_comb begin
    w_wl_sel = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      w_wl_sel[i] = (r_row == ROW_W'(i));
    end
  end

  bl_wl_phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .i_clk      (prog_clk),
    .i_rst_n    (prog_rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_expire   (w_expire)
  );

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_bl    <= '0;
      r_blb   <= '0;
      r_wl    <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            if (w_row_ok) begin
              r_state <= SETUP;
              r_row   <= cfg_row;
              r_bl    <= cfg_data;
              r_blb   <= ~cfg_data;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (w_expire) begin
            r_state <= PULSE;
            r_wl    <= w_wl_sel;
          end
        end
        PULSE: begin
          if (w_expire) begin
            r_state <= HOLD;
            r_wl    <= '0;
          end
        end
        HOLD: begin
          if (w_expire) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
            r_bl    <= '0;
            r_blb   <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cfg_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign bl        = r_bl;
  assign blb       = r_blb;
  assign wl        = r_wl;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_bl_wl_programmer.sv
// tb/tb_bl_wl_programmer.sv - directed, table-driven bench for bl_wl_programmer
module tb_bl_wl_programmer;

  localparam int A_S = 1, A_P = 2, A_H = 1;
  localparam int B_S = 3, B_P = 5, B_H = 2;

  typedef struct packed {
    logic [7:0] wl;
    logic [7:0] bl;
    logic [7:0] blb;
    logic       ready;
    logic       busy;
    logic       done;
    logic       err;
  } obs_t;

  typedef struct {
    int         sel;
    logic [2:0] row;
    logic [7:0] data;
    logic [7:0] exp_wl;
    logic [7:0] exp_blb;
    bit         perturb;
  } vec_t;

  int checks;
  int errors;

  logic       clk;
  logic       rst_n;

  logic       a_valid, a_ready, a_busy, a_done, a_err;
  logic [2:0] a_row;
  logic [7:0] a_data, a_bl, a_blb, a_wl;

  logic       b_valid, b_ready, b_busy, b_done, b_err;
  logic [2:0] b_row;
  logic [7:0] b_data, b_bl, b_blb;
  logic [5:0] b_wl;

  logic [7:0] pa_bl, pa_wl, pb_bl;
  logic [5:0] pb_wl;

  bl_wl_programmer #(
    .NUM_ROWS (8), .NUM_COLS (8), .SETUP_CYC (A_S), .PULSE_CYC (A_P), .HOLD_CYC (A_H)
  ) dut_a (
    .prog_clk (clk), .prog_rst_n (rst_n), .cfg_valid (a_valid), .cfg_ready (a_ready),
    .cfg_row (a_row), .cfg_data (a_data), .bl (a_bl), .blb (a_blb), .wl (a_wl),
    .busy (a_busy), .done (a_done), .err (a_err)
  );

  bl_wl_programmer #(
    .NUM_ROWS (6), .NUM_COLS (8), .SETUP_CYC (B_S), .PULSE_CYC (B_P), .HOLD_CYC (B_H)
  ) dut_b (
    .prog_clk (clk), .prog_rst_n (rst_n), .cfg_valid (b_valid), .cfg_ready (b_ready),
    .cfg_row (b_row), .cfg_data (b_data), .bl (b_bl), .blb (b_blb), .wl (b_wl),
    .busy (b_busy), .done (b_done), .err (b_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic v, input logic [2:0] row, input logic [7:0] data);
    if (sel == 0) begin
      a_valid = v; a_row = row; a_data = data;
    end else begin
      b_valid = v; b_row = row; b_data = data;
    end
  endtask

  task automatic get_obs(input int sel, output obs_t o);
    o = '0;
    if (sel == 0) begin
      o.wl = a_wl; o.bl = a_bl; o.blb = a_blb;
      o.ready = a_ready; o.busy = a_busy; o.done = a_done; o.err = a_err;
    end else begin
      o.wl = 8'(b_wl); o.bl = b_bl; o.blb = b_blb;
      o.ready = b_ready; o.busy = b_busy; o.done = b_done; o.err = b_err;
    end
  endtask

  task automatic cmp_obs(input string tag, input obs_t o, input obs_t e);
    chk({tag, " wl"},    32'(o.wl),    32'(e.wl));
    chk({tag, " bl"},    32'(o.bl),    32'(e.bl));
    chk({tag, " blb"},   32'(o.blb),   32'(e.blb));
    chk({tag, " ready"}, 32'(o.ready), 32'(e.ready));
    chk({tag, " busy"},  32'(o.busy),  32'(e.busy));
    chk({tag, " done"},  32'(o.done),  32'(e.done));
    chk({tag, " err"},   32'(o.err),   32'(e.err));
  endtask

  function automatic obs_t idle_exp(input logic e_err);
    obs_t e;
    e = '0;
    e.ready = 1'b1;
    e.err = e_err;
    return e;
  endfunction

  // Expected outputs k cycles after the acceptance edge.
  function automatic obs_t exp_at(input int k, input logic [7:0] wl, input logic [7:0] bl,
                                  input logic [7:0] blb, input int s, input int p, input int h);
    obs_t e;
    e = '0;
    if (k <= s + p + h) begin
      e.busy = 1'b1;
      e.bl = bl;
      e.blb = blb;
      if (k > s && k <= s + p) e.wl = wl;
    end else begin
      e.done = 1'b1;
      e.ready = 1'b1;
    end
    return e;
  endfunction

  task automatic run_write(input vec_t v, input string tag);
    int s, p, h, n;
    obs_t o;
    s = (v.sel == 0) ? A_S : B_S;
    p = (v.sel == 0) ? A_P : B_P;
    h = (v.sel == 0) ? A_H : B_H;
    n = s + p + h + 1;
    set_req(v.sel, 1'b1, v.row, v.data);
    @(posedge clk); #1;
    set_req(v.sel, 1'b0, v.row, v.data);
    for (int k = 1; k <= n; k++) begin
      if (v.perturb) set_req(v.sel, 1'b0, 3'(~v.row ^ 3'(k)), v.data ^ 8'(k * 37));
      get_obs(v.sel, o);
      cmp_obs($sformatf("%s k%0d", tag, k), o, exp_at(k, v.exp_wl, v.data, v.exp_blb, s, p, h));
      @(posedge clk); #1;
    end
    get_obs(v.sel, o);
    cmp_obs({tag, " after"}, o, idle_exp(1'b0));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_a_onehot", 32'($onehot0(a_wl)), 32'd1);
      chk("inv_b_onehot", 32'($onehot0(b_wl)), 32'd1);
      if (a_busy) chk("inv_a_compl", 32'(a_bl), 32'(8'(~a_blb)));
      if (b_busy) chk("inv_b_compl", 32'(b_bl), 32'(8'(~b_blb)));
      if (a_wl != 0 || pa_wl != 0) chk("inv_a_stable", 32'(a_bl), 32'(pa_bl));
      if (b_wl != 0 || pb_wl != 0) chk("inv_b_stable", 32'(b_bl), 32'(pb_bl));
    end
    pa_bl <= a_bl;
    pa_wl <= a_wl;
    pb_bl <= b_bl;
    pb_wl <= b_wl;
  end

  vec_t vecs[7];
  obs_t o;

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{sel: 0, row: 3'd3, data: 8'hA5, exp_wl: 8'h08, exp_blb: 8'h5A, perturb: 1'b0};
    vecs[1] = '{sel: 0, row: 3'd0, data: 8'h00, exp_wl: 8'h01, exp_blb: 8'hFF, perturb: 1'b0};
    vecs[2] = '{sel: 0, row: 3'd7, data: 8'hFF, exp_wl: 8'h80, exp_blb: 8'h00, perturb: 1'b1};
    vecs[3] = '{sel: 0, row: 3'd1, data: 8'h5A, exp_wl: 8'h02, exp_blb: 8'hA5, perturb: 1'b0};
    vecs[4] = '{sel: 0, row: 3'd6, data: 8'h81, exp_wl: 8'h40, exp_blb: 8'h7E, perturb: 1'b1};
    vecs[5] = '{sel: 1, row: 3'd5, data: 8'hC3, exp_wl: 8'h20, exp_blb: 8'h3C, perturb: 1'b1};
    vecs[6] = '{sel: 1, row: 3'd0, data: 8'h0F, exp_wl: 8'h01, exp_blb: 8'hF0, perturb: 1'b0};

    rst_n = 1'b0;
    set_req(0, 1'b1, 3'd3, 8'hA5);
    set_req(1, 1'b1, 3'd2, 8'h11);
    repeat (3) @(posedge clk);
    #1;
    get_obs(0, o); cmp_obs("reset_a", o, idle_exp(1'b0));
    get_obs(1, o); cmp_obs("reset_b", o, idle_exp(1'b0));
    set_req(0, 1'b0, 3'd0, 8'h00);
    set_req(1, 1'b0, 3'd0, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;
    get_obs(0, o); cmp_obs("post_reset_a", o, idle_exp(1'b0));

    for (int i = 0; i < 7; i++) run_write(vecs[i], $sformatf("vec%0d", i));

    set_req(0, 1'b1, 3'd0, 8'h01);
    @(posedge clk); #1;
    set_req(0, 1'b1, 3'd7, 8'hFF);
    for (int k = 1; k <= 10; k++) begin
      get_obs(0, o);
      if (k <= 5) cmp_obs($sformatf("b2b k%0d", k), o, exp_at(k, 8'h01, 8'h01, 8'hFE, A_S, A_P, A_H));
      else        cmp_obs($sformatf("b2b k%0d", k), o, exp_at(k - 5, 8'h80, 8'hFF, 8'h00, A_S, A_P, A_H));
      if (k == 6) set_req(0, 1'b0, 3'd0, 8'h00);
      @(posedge clk); #1;
    end
    get_obs(0, o); cmp_obs("b2b after", o, idle_exp(1'b0));

    for (int r = 6; r <= 7; r++) begin
      set_req(1, 1'b1, 3'(r), 8'h55);
      @(posedge clk); #1;
      set_req(1, 1'b0, 3'd0, 8'h00);
      get_obs(1, o); cmp_obs($sformatf("err row%0d", r), o, idle_exp(1'b1));
      for (int k = 1; k <= 3; k++) begin
        @(posedge clk); #1;
        get_obs(1, o); cmp_obs($sformatf("err row%0d k%0d", r, k), o, idle_exp(1'b0));
      end
    end

    set_req(0, 1'b1, 3'd2, 8'h3C);
    @(posedge clk); #1;
    set_req(0, 1'b0, 3'd0, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort pulse2 wl", 32'(a_wl), 32'h04);
    rst_n = 1'b0;
    #1;
    get_obs(0, o); cmp_obs("abort async", o, idle_exp(1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      get_obs(0, o); cmp_obs($sformatf("abort idle k%0d", k), o, idle_exp(1'b0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
